// File: rtl/traffic_light_monitor_if.sv
// Bus between the junction controller outputs and the traffic-light monitor:
// the observed light pair and clear strobe in, decoded status and sticky errors out.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 8
);
    logic             main_road;
    logic             side_road;
    logic             clear;
    logic [1:0]       phase;
    logic [CNT_W-1:0] dwell;
    logic [CNT_W-1:0] cycle_count;
    logic             conflict_err;
    logic             seq_err;
    logic             dwell_err;
    logic             fault;

    modport master (
        output main_road, side_road, clear,
        input  phase, dwell, cycle_count, conflict_err, seq_err, dwell_err, fault
    );

    modport slave (
        input  main_road, side_road, clear,
        output phase, dwell, cycle_count, conflict_err, seq_err, dwell_err, fault
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the junction controller's light pair: phase decode,
// dwell/cycle counting and sticky error flags. Optional green-dwell limits: TL_MON_DWELL_CHECK_EN.
module traffic_light_monitor #(
    parameter int CNT_W     = 8,
    parameter int MIN_GREEN = 1,
    parameter int MAX_GREEN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    traffic_light_monitor_if.slave bus
);

`ifdef TL_MON_DWELL_CHECK_EN
    localparam bit DWELL_CHK = 1'b1;
`else
    localparam bit DWELL_CHK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_UNKNOWN,
        S_RED,
        S_MAIN,
        S_SIDE,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        IN_RED,
        IN_MAIN,
        IN_SIDE,
        IN_CONFLICT
    } obs_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic             conflict_q, conflict_d;
    logic             seq_q, seq_d;
    logic             dwell_err_q, dwell_err_d;

    obs_e             obs;
    state_e           obs_state;
    logic             in_green;
    logic             below_min;
    logic             at_max;
    logic [1:0]       phase;

    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        obs       = IN_CONFLICT;
        obs_state = S_FAULT;
        unique case ({bus.main_road, bus.side_road})
            2'b10:   begin obs = IN_MAIN; obs_state = S_MAIN; end
            2'b01:   begin obs = IN_SIDE; obs_state = S_SIDE; end
            2'b00:   begin obs = IN_RED;  obs_state = S_RED;  end
            default: begin obs = IN_CONFLICT; obs_state = S_FAULT; end
        endcase
    end

    assign in_green  = (state_q == S_MAIN) || (state_q == S_SIDE);
    assign below_min = 32'(dwell_q) <  MIN_GREEN;
    assign at_max    = 32'(dwell_q) >= MAX_GREEN;

    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        cycle_d     = cycle_q;
        // clear drops the sticky flags; an error event below in the same cycle re-sets them
        conflict_d  = bus.clear ? 1'b0 : conflict_q;
        seq_d       = bus.clear ? 1'b0 : seq_q;
        dwell_err_d = bus.clear ? 1'b0 : dwell_err_q;

        unique case (state_q)
            S_FAULT: begin
                if (bus.clear) begin
                    state_d = S_UNKNOWN;
                end
            end

            S_UNKNOWN: begin
                if (obs == IN_CONFLICT) begin
                    state_d    = S_FAULT;
                    conflict_d = 1'b1;
                end else begin
                    state_d = obs_state;
                    dwell_d = CNT_ONE;
                end
            end

            default: begin
                if (obs == IN_CONFLICT) begin
                    state_d    = S_FAULT;
                    conflict_d = 1'b1;
                    if (DWELL_CHK && in_green && below_min) begin
                        dwell_err_d = 1'b1;
                    end
                end else if (obs_state == state_q) begin
                    dwell_d = (dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_ONE;
                    if (DWELL_CHK && in_green && at_max) begin
                        dwell_err_d = 1'b1;
                    end
                end else begin
                    state_d = obs_state;
                    dwell_d = CNT_ONE;
                    if (DWELL_CHK && in_green && below_min) begin
                        dwell_err_d = 1'b1;
                    end
                    if (state_q == S_RED && obs == IN_SIDE) begin
                        seq_d = 1'b1;
                    end
                    if (state_q == S_SIDE && obs == IN_MAIN && cycle_q != CNT_MAX) begin
                        cycle_d = cycle_q + CNT_ONE;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_UNKNOWN;
            dwell_q     <= '0;
            cycle_q     <= '0;
            conflict_q  <= 1'b0;
            seq_q       <= 1'b0;
            dwell_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            cycle_q     <= cycle_d;
            conflict_q  <= conflict_d;
            seq_q       <= seq_d;
            dwell_err_q <= dwell_err_d;
        end
    end

    always_comb begin
        phase = 2'b11;
        unique case (state_q)
            S_MAIN:  phase = 2'b00;
            S_SIDE:  phase = 2'b01;
            S_RED:   phase = 2'b10;
            default: phase = 2'b11;
        endcase
    end

    assign bus.phase        = phase;
    assign bus.dwell        = dwell_q;
    assign bus.cycle_count  = cycle_q;
    assign bus.conflict_err = conflict_q;
    assign bus.seq_err      = seq_q;
    assign bus.dwell_err    = DWELL_CHK ? dwell_err_q : 1'b0;
    assign bus.fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomised and directed bench for traffic_light_monitor: two instances (8-bit and
// 4-bit counters) share one stimulus stream and are compared against a phase-level model.
module tb_traffic_light_monitor;

`ifdef TL_MON_DWELL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam int P_MAIN = 0;
    localparam int P_SIDE = 1;
    localparam int P_RED  = 2;
    localparam int P_UNK  = 3;

    typedef struct {
        int cur;
        bit flt;
        int dwell;
        int cyc;
        bit conf;
        bit seq;
        bit derr;
    } mdl_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    mdl_t m8;
    mdl_t m4;
    logic [43:0] got;
    logic [43:0] want;

    traffic_light_monitor_if #(.CNT_W(8)) bus8 ();
    traffic_light_monitor_if #(.CNT_W(4)) bus4 ();

    assign bus4.main_road = bus8.main_road;
    assign bus4.side_road = bus8.side_road;
    assign bus4.clear     = bus8.clear;

    traffic_light_monitor #(.CNT_W(8), .MIN_GREEN(2), .MAX_GREEN(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    traffic_light_monitor #(.CNT_W(4), .MIN_GREEN(1), .MAX_GREEN(8)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mreset();
        mdl_t r;
        r.cur = P_UNK; r.flt = 0; r.dwell = 0; r.cyc = 0;
        r.conf = 0; r.seq = 0; r.derr = 0;
        return r;
    endfunction

    // One observed cycle of the light pair, judged by the junction rules.
    function automatic mdl_t mstep(mdl_t m, bit mr, bit sr, bit clr, int cmax, int ming, int maxg);
        mdl_t r = m;
        int   nxt;
        bit   green;
        if (clr) begin r.conf = 0; r.seq = 0; r.derr = 0; end
        if (m.flt) begin
            if (clr) begin r.flt = 0; r.cur = P_UNK; end
            return r;
        end
        green = (m.cur == P_MAIN) || (m.cur == P_SIDE);
        if (mr && sr) begin
            r.conf = 1; r.flt = 1;
            if (CHK && green && m.dwell < ming) r.derr = 1;
            return r;
        end
        nxt = mr ? P_MAIN : (sr ? P_SIDE : P_RED);
        if (m.cur == P_UNK) begin
            r.cur = nxt; r.dwell = 1;
        end else if (nxt == m.cur) begin
            if (CHK && green && m.dwell >= maxg) r.derr = 1;
            r.dwell = (m.dwell + 1 > cmax) ? cmax : m.dwell + 1;
        end else begin
            if (CHK && green && m.dwell < ming) r.derr = 1;
            if (m.cur == P_RED && nxt == P_SIDE) r.seq = 1;
            if (m.cur == P_SIDE && nxt == P_MAIN && m.cyc < cmax) r.cyc = m.cyc + 1;
            r.cur = nxt; r.dwell = 1;
        end
        return r;
    endfunction

    function automatic logic [21:0] pack(logic [1:0] ph, int dw, int cy, bit c, bit s, bit d, bit f);
        return {ph, 8'(dw), 8'(cy), c, s, d, f};
    endfunction

    function automatic logic [21:0] expect_of(mdl_t m);
        logic [1:0] ph;
        ph = m.flt ? 2'b11 : 2'(m.cur);
        return pack(ph, m.dwell, m.cyc, m.conf, m.seq, m.derr, m.flt);
    endfunction

    function automatic logic [43:0] observe();
        return {bus8.phase, bus8.dwell, bus8.cycle_count,
                bus8.conflict_err, bus8.seq_err, bus8.dwell_err, bus8.fault,
                bus4.phase, 4'b0, bus4.dwell, 4'b0, bus4.cycle_count,
                bus4.conflict_err, bus4.seq_err, bus4.dwell_err, bus4.fault};
    endfunction

    task automatic step(input bit mr, input bit sr, input bit clr);
        bus8.main_road = mr;
        bus8.side_road = sr;
        bus8.clear     = clr;
        @(posedge clk);
        m8 = mstep(m8, mr, sr, clr, 255, 2, 3);
        m4 = mstep(m4, mr, sr, clr, 15, 1, 8);
        #1;
    endtask

    task automatic test_reset();
        got  = observe();
        want = {pack(2'b11, 0, 0, 0, 0, 0, 0), pack(2'b11, 0, 0, 0, 0, 0, 0)};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", got, want);
        end
    endtask

    task automatic test_alternate();
        step(0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            step(i % 2 == 0, i % 2 == 1, 0);
            got = observe(); want = {expect_of(m8), expect_of(m4)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL alternate cyc %0d: got %h want %h", i, got, want);
            end
        end
        n_checks++;
        if (bus8.cycle_count !== 8'd5) begin
            n_fail++;
            $display("FAIL alternate cycle_count: got %0d want 5", bus8.cycle_count);
        end
    endtask

    task automatic test_seq_err();
        step(0, 0, 1);
        step(0, 1, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.seq_err !== 1'b1 || bus8.phase !== 2'b01) begin
            n_fail++;
            $display("FAIL seq_err set: got %h want %h", got, want);
        end
        step(0, 1, 1);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_err clear: got %h want %h", got, want);
        end
        // error raised in the same cycle as clear must win
        step(0, 0, 0);
        step(0, 1, 1);
        n_checks++;
        if (bus8.seq_err !== 1'b1 || bus4.seq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_err vs clear: got %b/%b want 1/1", bus8.seq_err, bus4.seq_err);
        end
    endtask

    task automatic test_conflict();
        step(1, 0, 1);
        step(1, 1, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.fault !== 1'b1 || bus8.phase !== 2'b11) begin
            n_fail++;
            $display("FAIL conflict entry: got %h want %h", got, want);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'($urandom), 1'($urandom), 0);
            got = observe(); want = {expect_of(m8), expect_of(m4)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL conflict frozen %0d: got %h want %h", i, got, want);
            end
        end
        step(1'($urandom), 1'($urandom), 1);
        step(1, 0, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.fault !== 1'b0 || bus8.phase !== 2'b00) begin
            n_fail++;
            $display("FAIL conflict recover: got %h want %h", got, want);
        end
        step(1, 1, 1);
        n_checks++;
        if (bus8.conflict_err !== 1'b1 || bus8.fault !== 1'b1) begin
            n_fail++;
            $display("FAIL conflict vs clear: got %b%b want 11", bus8.conflict_err, bus8.fault);
        end
    endtask

    task automatic test_saturation();
        step(0, 0, 1);
        step(0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(i % 2 == 0, i % 2 == 1, 0);
            got = observe(); want = {expect_of(m8), expect_of(m4)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturate alt %0d: got %h want %h", i, got, want);
            end
        end
        n_checks++;
        if (bus4.cycle_count !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate cycle_count: got %0d want 15", bus4.cycle_count);
        end
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus4.dwell !== 4'd15) begin
            n_fail++;
            $display("FAIL saturate dwell: got %h want %h", got, want);
        end
    endtask

    task automatic test_dwell_limits();
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            got = observe(); want = {expect_of(m8), expect_of(m4)};
            n_checks++;
            if (got !== want || bus8.dwell_err !== ((i == 3) ? CHK : 1'b0)) begin
                n_fail++;
                $display("FAIL dwell max %0d: got %h want %h", i, got, want);
            end
        end
        step(0, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.dwell_err !== CHK) begin
            n_fail++;
            $display("FAIL dwell min: got %h want %h", got, want);
        end
    endtask

    task automatic test_random();
        int r;
        step(0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       step(1, 1, $urandom_range(0, 9) == 0);
            else if (r < 30) step(0, 0, $urandom_range(0, 19) == 0);
            else if (r < 65) step(1, 0, $urandom_range(0, 19) == 0);
            else             step(0, 1, $urandom_range(0, 19) == 0);
            if (m8.flt && $urandom_range(0, 3) == 0) step(0, 0, 1);
            got = observe(); want = {expect_of(m8), expect_of(m4)};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL random %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want || bus8.seq_err !== 1'b1) begin
            n_fail++;
            $display("FAIL pre-reset: got %h want %h", got, want);
        end
        rst_n = 1'b0;
        #1;
        got  = observe();
        want = {pack(2'b11, 0, 0, 0, 0, 0, 0), pack(2'b11, 0, 0, 0, 0, 0, 0)};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async reset: got %h want %h", got, want);
        end
        m8 = mreset();
        m4 = mreset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        got = observe(); want = {expect_of(m8), expect_of(m4)};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL post-reset: got %h want %h", got, want);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus8.main_road = 1'b0;
        bus8.side_road = 1'b0;
        bus8.clear     = 1'b0;
        m8 = mreset();
        m4 = mreset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_alternate();
        test_seq_err();
        test_conflict();
        test_saturation();
        test_dwell_limits();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
